// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the ticket vending sequencer
package vend_pkg;

    localparam int VW             = 8;
    localparam int MAX_CREDIT_DEF = 250;
    localparam int TIMEOUT_DEF    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_CHG_REQ,
        S_CHG_DATA,
        S_CHG_WAIT,
        S_FAULT
    } state_t;

endpackage

// File: rtl/vend_ctrl_if.sv
// rtl/vend_ctrl_if.sv - ready/data/completion handshake towards the change block
// Ports (master = vend_ctrl side):
//   chg_rdy  master->slave  one-cycle payout request
//   chg_data master->slave  payout amount, valid the cycle after chg_rdy
//   chg_cmp  slave->master  payout completion
interface vend_ctrl_if;
    import vend_pkg::*;

    logic          chg_rdy;
    logic [VW-1:0] chg_data;
    logic          chg_cmp;

    modport master (output chg_rdy, output chg_data, input chg_cmp);
    modport slave  (input chg_rdy, input chg_data, output chg_cmp);

endinterface

// File: rtl/vend_credit.sv
// rtl/vend_credit.sv - credit accumulator, overflow check, price latch and credit>=price compare
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   coin_add, coin_val  add coin_val to credit (caller has already checked over)
//   price_load/val      latch a new price
//   price_clr           clear price only
//   clr                 clear credit and price (has priority)
//   credit, price       registered values
//   over                credit+coin_val would exceed MAX_CREDIT
//   ge                  price is set and credit covers it
module vend_credit
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_add,
    input  logic [VW-1:0] coin_val,
    input  logic          price_load,
    input  logic [VW-1:0] price_val,
    input  logic          price_clr,
    input  logic          clr,
    output logic [VW-1:0] credit,
    output logic [VW-1:0] price,
    output logic          over,
    output logic          ge
);

    localparam logic [VW:0] MAXC = MAX_CREDIT[VW:0];

    // One extra bit so a wrapping sum still reads as an overflow.
    logic [VW:0] sum;

    assign sum  = {1'b0, credit} + {1'b0, coin_val};
    assign over = sum > MAXC;
    assign ge   = (price != '0) && (credit >= price);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit <= '0;
            price  <= '0;
        end else if (clr) begin
            credit <= '0;
            price  <= '0;
        end else begin
            if (coin_add)
                credit <= sum[VW-1:0];
            if (price_clr)
                price <= '0;
            else if (price_load)
                price <= price_val;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - ticket vending transaction sequencer driving the change block
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   coin_vld, coin_val       coin strobe and value
//   sel_vld, sel_price       ticket select strobe and price (0 ignored)
//   cancel                   abort request, honoured in COLLECT only
//   chg                      handshake to the change block (master side)
//   coin_rej, ticket_vld     one-cycle pulses
//   busy, fault, credit      status outputs
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = MAX_CREDIT_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_vld,
    input  logic [VW-1:0]      coin_val,
    input  logic               sel_vld,
    input  logic [VW-1:0]      sel_price,
    input  logic               cancel,
    vend_ctrl_if.master        chg,
    output logic               coin_rej,
    output logic               ticket_vld,
    output logic               busy,
    output logic               fault,
    output logic [VW-1:0]      credit
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT - 1);

    state_t        state, next;
    logic [VW-1:0] price, refund, data_q;
    logic [CW-1:0] cnt;
    logic          over, ge, rdy_q;
    logic          coin_add, price_load, price_clr, clr, rej;

    vend_credit #(.MAX_CREDIT(MAX_CREDIT)) u_credit (
        .clk        (clk),
        .rst        (rst),
        .coin_add   (coin_add),
        .coin_val   (coin_val),
        .price_load (price_load),
        .price_val  (sel_price),
        .price_clr  (price_clr),
        .clr        (clr),
        .credit     (credit),
        .price      (price),
        .over       (over),
        .ge         (ge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next       = state;
        coin_add   = 1'b0;
        price_load = 1'b0;
        price_clr  = 1'b0;
        clr        = 1'b0;
        rej        = 1'b0;
        case (state)
            S_IDLE: begin
                if (coin_vld) begin
                    if (over) begin
                        rej = 1'b1;
                    end else begin
                        coin_add = 1'b1;
                        next     = S_COLLECT;
                    end
                end else if (sel_vld && sel_price != '0) begin
                    price_load = 1'b1;
                    next       = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    rej       = coin_vld;
                    price_clr = 1'b1;
                    if (credit == '0) begin
                        clr  = 1'b1;
                        next = S_IDLE;
                    end else begin
                        next = S_CHG_REQ;
                    end
                end else if (coin_vld) begin
                    if (over)
                        rej = 1'b1;
                    else
                        coin_add = 1'b1;
                end else if (sel_vld) begin
                    price_load = (sel_price != '0);
                end else if (ge) begin
                    // Only a quiet cycle issues, so the compare always sees
                    // the credit and price that ISSUE will refund against.
                    next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rej = coin_vld;
                if (credit == price) begin
                    clr  = 1'b1;
                    next = S_IDLE;
                end else begin
                    next = S_CHG_REQ;
                end
            end
            S_CHG_REQ: begin
                rej  = coin_vld;
                next = S_CHG_DATA;
            end
            S_CHG_DATA: begin
                rej  = coin_vld;
                next = S_CHG_WAIT;
            end
            S_CHG_WAIT: begin
                rej = coin_vld;
                if (chg.chg_cmp) begin
                    clr  = 1'b1;
                    next = S_IDLE;
                end else if (cnt == TMAX) begin
                    next = S_FAULT;
                end
            end
            S_FAULT: begin
                rej = coin_vld;
            end
            default: begin
                next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refund <= '0;
        end else begin
            case (state)
                S_COLLECT:  if (cancel) refund <= credit;
                S_ISSUE:    refund <= credit - price;
                S_CHG_WAIT: if (chg.chg_cmp) refund <= '0;
                default:    refund <= refund;
            endcase
        end
    end

    // Counts cycles spent in CHG_WAIT; any other state holds it at zero,
    // so it is clear on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state == S_CHG_WAIT)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // Outputs are registered from the next state so they line up with the
    // state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_rej   <= 1'b0;
            ticket_vld <= 1'b0;
            rdy_q      <= 1'b0;
            data_q     <= '0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            coin_rej   <= rej;
            ticket_vld <= (next == S_ISSUE);
            rdy_q      <= (next == S_CHG_REQ);
            data_q     <= (next == S_CHG_DATA) ? refund : '0;
            busy       <= (next != S_IDLE) && (next != S_COLLECT);
            fault      <= (next == S_FAULT);
        end
    end

    assign chg.chg_rdy  = rdy_q;
    assign chg.chg_data = data_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - table-driven self-checking bench for vend_ctrl
module tb_vend_ctrl;

    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_vld = 1'b0;
    logic [7:0] coin_val = '0;
    logic       sel_vld = 1'b0;
    logic [7:0] sel_price = '0;
    logic       cancel = 1'b0;
    logic       coin_rej, ticket_vld, busy, fault;
    logic [7:0] credit;

    int n_tests = 0;
    int n_fail  = 0;

    vend_ctrl_if chg_bus ();

    vend_ctrl #(.MAX_CREDIT(250), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_vld   (coin_vld),
        .coin_val   (coin_val),
        .sel_vld    (sel_vld),
        .sel_price  (sel_price),
        .cancel     (cancel),
        .chg        (chg_bus),
        .coin_rej   (coin_rej),
        .ticket_vld (ticket_vld),
        .busy       (busy),
        .fault      (fault),
        .credit     (credit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cv;
        logic [7:0] cval;
        logic       sv;
        logic [7:0] sp;
        logic       can;
        logic       cmp;
        logic       rej;
        logic       tk;
        logic       rdy;
        logic [7:0] data;
        logic       bsy;
        logic       flt;
        logic [7:0] cred;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(logic cv, logic [7:0] cval, logic sv, logic [7:0] sp,
                               logic can, logic cmp, logic rej, logic tk, logic rdy,
                               logic [7:0] data, logic bsy, logic flt, logic [7:0] cred);
        vec_t r;
        r = '{cv, cval, sv, sp, can, cmp, rej, tk, rdy, data, bsy, flt, cred};
        return r;
    endfunction

    // {coin_rej, ticket_vld, chg_rdy, chg_data, busy, fault, credit}
    function automatic logic [20:0] obs();
        return {coin_rej, ticket_vld, chg_bus.chg_rdy, chg_bus.chg_data, busy, fault, credit};
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got rej/tk/rdy/data/busy/flt/cred=%h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t x, input string name);
        coin_vld        = x.cv;
        coin_val        = x.cval;
        sel_vld         = x.sv;
        sel_price       = x.sp;
        cancel          = x.can;
        chg_bus.chg_cmp = x.cmp;
        tick();
        coin_vld        = 1'b0;
        sel_vld         = 1'b0;
        cancel          = 1'b0;
        chg_bus.chg_cmp = 1'b0;
        check(name, obs(), {x.rej, x.tk, x.rdy, x.data, x.bsy, x.flt, x.cred});
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vt.size(); i++)
            apply(vt[i], $sformatf("%s[%0d]", name, i));
        vt.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        chg_bus.chg_cmp = 1'b0;
        tick();
        check("reset_state", obs(), '0);
        rst = 1'b1;
        tick();

        // exact-price purchase, then overpaid purchase with ignored 0 price
        vt.push_back(v(1,8'h0A,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h0A));
        vt.push_back(v(0,8'h00,1,8'h0A,0,0, 0,0,0,8'h00,0,0,8'h0A));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,1,0,8'h00,1,0,8'h0A));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h00));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h00));
        vt.push_back(v(1,8'hC8,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'hC8));
        vt.push_back(v(1,8'h32,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(0,8'h00,1,8'h00,0,0, 0,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(0,8'h00,1,8'hF0,0,0, 0,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,1,0,8'h00,1,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,1,8'h00,1,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h0A,1,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,1,0,8'hFA));
        run_table("buy");

        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("chg_wait_%0d", i), obs(), {3'b000, 8'h00, 1'b1, 1'b0, 8'hFA});
        end
        apply(v(0,8'h00,0,8'h00,0,1, 0,0,0,8'h00,0,0,8'h00), "chg_cmp_done");

        // overflow reject, cancel refund, cancel+coin priority, ignored strobes while busy
        vt.push_back(v(1,8'hFF,0,8'h00,0,0, 1,0,0,8'h00,0,0,8'h00));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h00));
        vt.push_back(v(1,8'hC8,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'hC8));
        vt.push_back(v(1,8'h32,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(1,8'h0A,0,8'h00,0,0, 1,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,1,0, 0,0,1,8'h00,1,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'hFA,1,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,1,0,8'hFA));
        vt.push_back(v(0,8'h00,0,8'h00,0,1, 0,0,0,8'h00,0,0,8'h00));
        vt.push_back(v(1,8'h14,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h14));
        vt.push_back(v(1,8'h05,0,8'h00,1,0, 1,0,1,8'h00,1,0,8'h14));
        vt.push_back(v(1,8'h01,1,8'h01,1,1, 1,0,0,8'h14,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,1, 0,0,0,8'h00,0,0,8'h00));
        run_table("cancel");

        // change block never completes -> fault after TIMEOUT cycles in CHG_WAIT
        vt.push_back(v(1,8'h14,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h14));
        vt.push_back(v(0,8'h00,1,8'h05,0,0, 0,0,0,8'h00,0,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,1,0,8'h00,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,1,8'h00,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h0F,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,1,0,8'h14));
        run_table("timeout");

        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (fault !== 1'b0)
                early++;
        end
        check("fault_not_early", {13'b0, 8'(early)}, 21'd0);
        tick();
        check("fault_at_timeout", obs(), {3'b000, 8'h00, 1'b1, 1'b1, 8'h14});
        apply(v(1,8'h05,1,8'h05,1,1, 1,0,0,8'h00,1,1,8'h14), "fault_rejects");
        apply(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,1,1,8'h14), "fault_sticky");
        rst = 1'b0;
        #1;
        check("fault_reset_async", obs(), '0);
        tick();
        rst = 1'b1;
        tick();
        check("fault_cleared", obs(), '0);

        // reset asserted mid CHG_WAIT, then a fresh transaction
        vt.push_back(v(1,8'h14,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h14));
        vt.push_back(v(0,8'h00,1,8'h05,0,0, 0,0,0,8'h00,0,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,1,0,8'h00,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,1,8'h00,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h0F,1,0,8'h14));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,1,0,8'h14));
        run_table("midreset");
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("midreset_async", obs(), '0);
        do_reset();
        check("midreset_idle", obs(), '0);
        vt.push_back(v(1,8'h0A,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h0A));
        vt.push_back(v(0,8'h00,1,8'h0A,0,0, 0,0,0,8'h00,0,0,8'h0A));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,1,0,8'h00,1,0,8'h0A));
        vt.push_back(v(0,8'h00,0,8'h00,0,0, 0,0,0,8'h00,0,0,8'h00));
        run_table("fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
